riscv_rst_gen: RTL and testbench
================================

// Module: riscv_rst_gen
// PURPOSE
//  Reset sequencer upstream of the clock divider. Turns the board reset, a raw
//  reset button and a core software-reset request into two staged active-low
//  resets: x_clk_rst_o drives the divider's x_reset, x_core_rst_o releases the
//  core SETTLE cycles later, once the divided clock is running.
// PARAMETERS
//  SYNC_STAGES  2   synchroniser depth for btn_i and sw_rst_req_i (>=2)
//  DEBOUNCE     16  cycles btn_i must be stable before a change is accepted (>=2)
//  HOLD         32  cycles both resets stay asserted after a trigger (>=1)
//  SETTLE       8   cycles between x_clk_rst_o and x_core_rst_o release (>=1)
// PORTS
//  clk_i         in   1  fast source clock, all logic posedge
//  x_reset       in   1  asynchronous active-low reset, asynchronous assert and deassert
//  btn_i         in   1  raw reset button, active-low, asynchronous, bouncing
//  sw_rst_req_i  in   1  core software-reset request, level from the divided-clock domain
//  x_clk_rst_o   out  1  active-low reset to the clock divider
//  x_core_rst_o  out  1  active-low reset to the core
//  rst_done_o    out  1  high in RUN only
// BEHAVIOUR
//  - x_reset low: state=RST_ALL, both resets 0, rst_done_o=0, counters 0,
//    sync flops 0, debounced button=1 (released). All outputs are registered.
//  - Cycle numbering: edge 0 = first posedge with x_reset high.
//  - Debounce: synced btn != debounced value -> count up; equal -> count=0.
//    When count==DEBOUNCE-1 and still different, the debounced value flips.
//    A debounced 1->0 flip is a press event.
//  - sw request: synchronised, rising edge detected. Edges count only in RUN.
//    A request held high does not retrigger.
//  - FSM (rst_state_t):
//     RST_ALL: both resets 0. Stays here while the debounced button is 0.
//              Otherwise go to HOLD with cnt=0.
//     HOLD:    cnt++. When cnt==HOLD-1, go to CLK_UP, set x_clk_rst_o<=1, cnt=0.
//     CLK_UP:  cnt++. When cnt==SETTLE-1, go to RUN, set x_core_rst_o<=1 and
//              rst_done_o<=1.
//     RUN:     hold outputs until a trigger.
//  - Trigger = press event, or sw edge while in RUN. From any state, the next
//    cycle has state=RST_ALL, cnt=0 and all three outputs 0.
//  - Power-up with button released: x_clk_rst_o rises after edge HOLD;
//    x_core_rst_o and rst_done_o rise after edge HOLD+SETTLE (defaults 32 / 40).
//  - Simultaneous press and sw edge give one sequence. A trigger in HOLD or
//    CLK_UP restarts from RST_ALL with the full HOLD.
//  - x_reset asserted mid-sequence: outputs go low immediately (asynchronous).
//  - Counter widths: $clog2 of max(HOLD, SETTLE, DEBOUNCE)+1. No wrap is
//    reachable; counters saturate defensively.
// STRUCTURE
//  - riscv_rst_pkg: typedef enum logic [1:0]
//    rst_state_t {RST_ALL, HOLD, CLK_UP, RUN}.
//  - Sub-module riscv_debounce (sync chain + stable counter; outputs level and
//    a fall pulse). It is instantiated for btn_i.
//  - The sw request uses a plain SYNC_STAGES flop chain plus edge register in
//    the top module.
// TESTING
//  - Power-up, btn_i=1, sw=0 -> x_clk_rst_o 1 after edge 32, x_core_rst_o
//    and rst_done_o 1 after edge 40.
//  - btn_i bounces 0/1 every 5 cycles for 100 cycles then returns to 1 -> no
//    trigger; outputs stay 1.
//  - btn_i held 0 for 200 cycles in RUN -> outputs 0 about DEBOUNCE+SYNC cycles
//    after the fall and held. After release + debounce, clk release after 32
//    cycles and core release after 40.
//  - sw_rst_req_i high for 12 cycles in RUN -> one sequence (40 cycles to
//    rst_done_o). Still high at sequence end -> no second sequence.
//  - sw edge at HOLD cnt=20 (raised after RUN and not lowered) -> ignored. A
//    press at HOLD cnt=20 -> restart with a full 32-cycle HOLD.
//  - x_reset pulsed low in CLK_UP -> all outputs 0 without waiting for a clock
//    edge. After release, the full power-up timing repeats.

Source files
------------

// File: rtl/riscv_rst_pkg.sv
// rtl/riscv_rst_pkg.sv - shared types and helpers for the reset sequencer
//
// Purpose: state encoding of the reset sequencer and a width helper.
// Ports:   none (package).

package riscv_rst_pkg;

  typedef enum logic [1:0] {
    RST_ALL = 2'd0,
    HOLD    = 2'd1,
    CLK_UP  = 2'd2,
    RUN     = 2'd3
  } rst_state_t;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/riscv_debounce.sv
// rtl/riscv_debounce.sv - synchroniser plus stable-count debouncer for a raw input
//
// Purpose: synchronises raw_i and accepts a level change only after the
//          synchronised value has differed from the accepted level for
//          DEBOUNCE consecutive cycles.
// Ports:
//   clk_i    in   1  source clock
//   x_reset  in   1  asynchronous active-low reset
//   raw_i    in   1  raw asynchronous input (idle high)
//   level_o  out  1  debounced level, 1 during reset
//   fall_o   out  1  one-cycle pulse on the cycle level_o becomes 0

module riscv_debounce #(
  parameter int SYNC_STAGES = 2,
  parameter int DEBOUNCE    = 16,
  parameter int CW          = $clog2(DEBOUNCE + 1)
) (
  input  logic clk_i,
  input  logic x_reset,
  input  logic raw_i,
  output logic level_o,
  output logic fall_o
);

  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE - 1);
  localparam logic [CW-1:0] CNT_MAX  = '1;

  logic [SYNC_STAGES-1:0] sync_q;
  logic [CW-1:0]          cnt_q;
  logic                   synced;

  assign synced = sync_q[SYNC_STAGES-1];

  always_ff @(posedge clk_i or negedge x_reset) begin
    if (!x_reset) begin
      sync_q  <= '0;
      cnt_q   <= '0;
      level_o <= 1'b1;
      fall_o  <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], raw_i};
      fall_o <= 1'b0;
      if (synced == level_o) begin
        cnt_q <= '0;
      end else if (cnt_q == CNT_LAST) begin
        // Last differing cycle of the window: accept the new level.
        level_o <= synced;
        cnt_q   <= '0;
        fall_o  <= ~synced;
      end else if (cnt_q != CNT_MAX) begin
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end

endmodule

// File: rtl/riscv_rst_gen.sv
// rtl/riscv_rst_gen.sv - staged reset sequencer for the clock divider and core
//
// Purpose: merges board reset, a debounced reset button and a core software
//          reset request into two staged active-low resets. The divider reset
//          releases HOLD cycles after a trigger, the core reset SETTLE cycles
//          after that.
// Ports:
//   clk_i         in   1  fast source clock
//   x_reset       in   1  asynchronous active-low reset
//   btn_i         in   1  raw reset button, active-low, bouncing
//   sw_rst_req_i  in   1  software reset request level (divided-clock domain)
//   x_clk_rst_o   out  1  active-low reset to the clock divider
//   x_core_rst_o  out  1  active-low reset to the core
//   rst_done_o    out  1  high only while the sequence is complete (RUN)

module riscv_rst_gen #(
  parameter int SYNC_STAGES = 2,
  parameter int DEBOUNCE    = 16,
  parameter int HOLD        = 32,
  parameter int SETTLE      = 8
) (
  input  logic clk_i,
  input  logic x_reset,
  input  logic btn_i,
  input  logic sw_rst_req_i,
  output logic x_clk_rst_o,
  output logic x_core_rst_o,
  output logic rst_done_o
);

  import riscv_rst_pkg::*;

  // The parameter HOLD shadows the state literal of the same name, so state
  // literals are always written package-qualified.
  localparam int CW = $clog2(max3(HOLD, SETTLE, DEBOUNCE) + 1);
  localparam logic [CW-1:0] HOLD_LAST   = CW'(HOLD - 1);
  localparam logic [CW-1:0] SETTLE_LAST = CW'(SETTLE - 1);

  logic btn_level;
  logic btn_fall;

  riscv_debounce #(
    .SYNC_STAGES (SYNC_STAGES),
    .DEBOUNCE    (DEBOUNCE),
    .CW          (CW)
  ) u_btn_debounce (
    .clk_i   (clk_i),
    .x_reset (x_reset),
    .raw_i   (btn_i),
    .level_o (btn_level),
    .fall_o  (btn_fall)
  );

  logic [SYNC_STAGES-1:0] sw_sync_q;
  logic                   sw_prev_q;
  logic                   sw_edge;

  always_ff @(posedge clk_i or negedge x_reset) begin
    if (!x_reset) begin
      sw_sync_q <= '0;
      sw_prev_q <= 1'b0;
    end else begin
      sw_sync_q <= {sw_sync_q[SYNC_STAGES-2:0], sw_rst_req_i};
      sw_prev_q <= sw_sync_q[SYNC_STAGES-1];
    end
  end

  assign sw_edge = sw_sync_q[SYNC_STAGES-1] & ~sw_prev_q;

  rst_state_t    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d, cnt_inc;
  logic          clk_rst_d, core_rst_d, done_d;
  logic          trigger;

  // A software request only counts once the core is actually running.
  assign trigger = btn_fall | (sw_edge & (state_q == riscv_rst_pkg::RUN));
  assign cnt_inc = (cnt_q == '1) ? cnt_q : cnt_q + 1'b1;

  always_ff @(posedge clk_i or negedge x_reset) begin
    if (!x_reset) begin
      state_q      <= riscv_rst_pkg::RST_ALL;
      cnt_q        <= '0;
      x_clk_rst_o  <= 1'b0;
      x_core_rst_o <= 1'b0;
      rst_done_o   <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      x_clk_rst_o  <= clk_rst_d;
      x_core_rst_o <= core_rst_d;
      rst_done_o   <= done_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    clk_rst_d  = x_clk_rst_o;
    core_rst_d = x_core_rst_o;
    done_d     = rst_done_o;
    if (trigger) begin
      state_d    = riscv_rst_pkg::RST_ALL;
      cnt_d      = '0;
      clk_rst_d  = 1'b0;
      core_rst_d = 1'b0;
      done_d     = 1'b0;
    end else begin
      unique case (state_q)
        riscv_rst_pkg::RST_ALL: begin
          cnt_d      = '0;
          clk_rst_d  = 1'b0;
          core_rst_d = 1'b0;
          done_d     = 1'b0;
          if (btn_level) state_d = riscv_rst_pkg::HOLD;
        end
        riscv_rst_pkg::HOLD: begin
          if (cnt_q == HOLD_LAST) begin
            state_d   = riscv_rst_pkg::CLK_UP;
            clk_rst_d = 1'b1;
            cnt_d     = '0;
          end else begin
            cnt_d = cnt_inc;
          end
        end
        riscv_rst_pkg::CLK_UP: begin
          if (cnt_q == SETTLE_LAST) begin
            state_d    = riscv_rst_pkg::RUN;
            core_rst_d = 1'b1;
            done_d     = 1'b1;
            cnt_d      = '0;
          end else begin
            cnt_d = cnt_inc;
          end
        end
        riscv_rst_pkg::RUN: begin
          state_d = riscv_rst_pkg::RUN;
        end
        default: state_d = riscv_rst_pkg::RST_ALL;
      endcase
    end
  end

endmodule

// File: tb/tb_riscv_rst_gen.sv
// tb/tb_riscv_rst_gen.sv - self-checking bench for riscv_rst_gen

module tb_riscv_rst_gen;

  localparam int SYNC   = 2;
  localparam int DEB    = 16;
  localparam int HOLD   = 32;
  localparam int SETTLE = 8;

  logic clk_i        = 1'b0;
  logic x_reset      = 1'b1;
  logic btn_i        = 1'b1;
  logic sw_rst_req_i = 1'b0;
  logic x_clk_rst_o, x_core_rst_o, rst_done_o;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk_i = ~clk_i;

  riscv_rst_gen #(
    .SYNC_STAGES (SYNC),
    .DEBOUNCE    (DEB),
    .HOLD        (HOLD),
    .SETTLE      (SETTLE)
  ) dut (
    .clk_i        (clk_i),
    .x_reset      (x_reset),
    .btn_i        (btn_i),
    .sw_rst_req_i (sw_rst_req_i),
    .x_clk_rst_o  (x_clk_rst_o),
    .x_core_rst_o (x_core_rst_o),
    .rst_done_o   (rst_done_o)
  );

  // Reference model: inputs reach the logic SYNC cycles late (delay queues),
  // the button is accepted after DEB consecutive differing samples, and a
  // sequence that starts on edge m releases the divider after edge m+HOLD
  // and the core after edge m+HOLD+SETTLE.
  bit bq[$];
  bit sq[$];
  bit m_s, m_w, m_wlast, m_swe, m_deb, m_press, m_inrst, m_clk, m_core;
  int m_run, m_start, m_n;

  always @(posedge clk_i or negedge x_reset) begin
    if (!x_reset) begin
      bq.delete();
      sq.delete();
      for (int i = 0; i < SYNC; i++) begin
        bq.push_back(1'b0);
        sq.push_back(1'b0);
      end
      m_wlast = 0; m_deb = 1; m_press = 0; m_inrst = 1;
      m_clk = 0; m_core = 0; m_run = 0; m_start = 0; m_n = 0;
    end else begin
      m_s = bq.pop_front(); bq.push_back(btn_i);
      m_w = sq.pop_front(); sq.push_back(sw_rst_req_i);
      m_swe = m_w && !m_wlast;
      m_wlast = m_w;
      if (m_press || (m_swe && m_core)) begin
        m_inrst = 1;
      end else if (m_inrst && m_deb) begin
        m_inrst = 0;
        m_start = m_n;
      end
      m_press = 0;
      if (m_s != m_deb) begin
        m_run++;
        if (m_run == DEB) begin
          m_deb = m_s;
          m_run = 0;
          m_press = !m_s;
        end
      end else begin
        m_run = 0;
      end
      m_clk  = !m_inrst && (m_n >= m_start + HOLD);
      m_core = !m_inrst && (m_n >= m_start + HOLD + SETTLE);
      m_n++;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired checks=%0d failures=%0d", n_checks, n_fail);
    $fatal(1, "watchdog");
  end

  task automatic cycle();
    @(posedge clk_i);
    @(negedge clk_i);
  endtask

  task automatic test_reset();
    logic [2:0] got;
    #1 x_reset = 1'b0;
    btn_i = 1'b1;
    sw_rst_req_i = 1'b0;
    repeat (3) cycle();
    got = {x_clk_rst_o, x_core_rst_o, rst_done_o};
    n_checks++;
    if (got !== 3'b000) begin
      n_fail++;
      $display("FAIL reset_outputs got=%b exp=000", got);
    end
  endtask

  task automatic test_power_up();
    logic [2:0] got, exp_dir;
    x_reset = 1'b1;
    for (int k = 0; k < HOLD + SETTLE + 5; k++) begin
      cycle();
      got = {x_clk_rst_o, x_core_rst_o, rst_done_o};
      exp_dir = {k >= HOLD, k >= HOLD + SETTLE, k >= HOLD + SETTLE};
      n_checks++;
      if (got !== exp_dir) begin
        n_fail++;
        $display("FAIL powerup_timing edge=%0d got=%b exp=%b", k, got, exp_dir);
      end
      n_checks++;
      if (got !== {m_clk, m_core, m_core}) begin
        n_fail++;
        $display("FAIL powerup_model edge=%0d got=%b exp=%b", k, got, {m_clk, m_core, m_core});
      end
    end
  endtask

  task automatic test_bounce();
    logic [2:0] got;
    for (int i = 0; i < 130; i++) begin
      btn_i = (i < 100) ? (((i / 5) % 2) == 1) : 1'b1;
      cycle();
      got = {x_clk_rst_o, x_core_rst_o, rst_done_o};
      n_checks++;
      if (got !== 3'b111 || got !== {m_clk, m_core, m_core}) begin
        n_fail++;
        $display("FAIL bounce cyc=%0d got=%b exp=111 model=%b", i, got, {m_clk, m_core, m_core});
      end
    end
  endtask

  task automatic test_button_hold();
    logic [2:0] got;
    int fall_at = -1;
    int clk_rise = -1;
    int core_rise = -1;
    btn_i = 1'b0;
    for (int i = 0; i < 200; i++) begin
      cycle();
      got = {x_clk_rst_o, x_core_rst_o, rst_done_o};
      if (fall_at < 0 && got == 3'b000) fall_at = i;
      n_checks++;
      if (got !== {m_clk, m_core, m_core}) begin
        n_fail++;
        $display("FAIL btn_hold_model cyc=%0d got=%b exp=%b", i, got, {m_clk, m_core, m_core});
      end
    end
    n_checks++;
    if (fall_at < DEB || fall_at > DEB + SYNC + 2) begin
      n_fail++;
      $display("FAIL btn_press_latency got=%0d exp=%0d..%0d", fall_at, DEB, DEB + SYNC + 2);
    end
    btn_i = 1'b1;
    for (int i = 0; i < 100; i++) begin
      cycle();
      if (clk_rise < 0 && x_clk_rst_o) clk_rise = i;
      if (core_rise < 0 && x_core_rst_o) core_rise = i;
      got = {x_clk_rst_o, x_core_rst_o, rst_done_o};
      n_checks++;
      if (got !== {m_clk, m_core, m_core}) begin
        n_fail++;
        $display("FAIL btn_release_model cyc=%0d got=%b exp=%b", i, got, {m_clk, m_core, m_core});
      end
    end
    n_checks++;
    if (clk_rise < HOLD + DEB || clk_rise > HOLD + DEB + SYNC + 2) begin
      n_fail++;
      $display("FAIL btn_release_clk got=%0d exp=%0d..%0d", clk_rise, HOLD + DEB, HOLD + DEB + SYNC + 2);
    end
    n_checks++;
    if (core_rise - clk_rise != SETTLE) begin
      n_fail++;
      $display("FAIL btn_release_settle got=%0d exp=%0d", core_rise - clk_rise, SETTLE);
    end
  endtask

  task automatic test_sw_req();
    logic [2:0] got;
    int falls, rises, fall_at, rise_at;
    logic prev;
    for (int pass = 0; pass < 2; pass++) begin
      falls = 0; rises = 0; fall_at = -1; rise_at = -1;
      prev = rst_done_o;
      for (int i = 0; i < 100; i++) begin
        sw_rst_req_i = (pass == 1) ? 1'b1 : (i < 12);
        cycle();
        if (prev && !rst_done_o) begin falls++; fall_at = i; end
        if (!prev && rst_done_o) begin rises++; rise_at = i; end
        prev = rst_done_o;
        got = {x_clk_rst_o, x_core_rst_o, rst_done_o};
        n_checks++;
        if (got !== {m_clk, m_core, m_core}) begin
          n_fail++;
          $display("FAIL sw_req_model pass=%0d cyc=%0d got=%b exp=%b", pass, i, got, {m_clk, m_core, m_core});
        end
      end
      n_checks++;
      if (falls != 1 || rises != 1 || rise_at - fall_at != HOLD + SETTLE + 1 || !rst_done_o) begin
        n_fail++;
        $display("FAIL sw_req_single pass=%0d got falls=%0d rises=%0d gap=%0d exp 1/1/%0d",
                 pass, falls, rises, rise_at - fall_at, HOLD + SETTLE + 1);
      end
    end
    sw_rst_req_i = 1'b0;
    repeat (5) cycle();
  endtask

  task automatic test_hold_triggers();
    logic [2:0] got;
    int rises, rise_at, clk_rise;
    logic prev;
    rises = 0; rise_at = -1;
    prev = rst_done_o;
    for (int i = 0; i < 60; i++) begin
      sw_rst_req_i = (i < 3) || (i >= 21);
      cycle();
      if (!prev && rst_done_o) begin rises++; rise_at = i; end
      prev = rst_done_o;
      got = {x_clk_rst_o, x_core_rst_o, rst_done_o};
      n_checks++;
      if (got !== {m_clk, m_core, m_core}) begin
        n_fail++;
        $display("FAIL hold_sw_model cyc=%0d got=%b exp=%b", i, got, {m_clk, m_core, m_core});
      end
    end
    n_checks++;
    if (rises != 1 || rise_at != SYNC + 1 + HOLD + SETTLE) begin
      n_fail++;
      $display("FAIL hold_sw_ignored got rises=%0d at=%0d exp 1 at %0d", rises, rise_at, SYNC + 1 + HOLD + SETTLE);
    end
    sw_rst_req_i = 1'b0;
    repeat (5) cycle();
    clk_rise = -1;
    for (int i = 0; i < 100; i++) begin
      sw_rst_req_i = (i < 3);
      btn_i = !(i >= 5 && i < 30);
      cycle();
      if (clk_rise < 0 && i > 3 && x_clk_rst_o) clk_rise = i;
      got = {x_clk_rst_o, x_core_rst_o, rst_done_o};
      n_checks++;
      if (got !== {m_clk, m_core, m_core}) begin
        n_fail++;
        $display("FAIL hold_press_model cyc=%0d got=%b exp=%b", i, got, {m_clk, m_core, m_core});
      end
    end
    n_checks++;
    if (clk_rise < 5 + SYNC + DEB + HOLD || !rst_done_o) begin
      n_fail++;
      $display("FAIL hold_press_restart got clk_rise=%0d done=%b exp >=%0d done=1",
               clk_rise, rst_done_o, 5 + SYNC + DEB + HOLD);
    end
  endtask

  task automatic test_random();
    logic [2:0] got;
    int btn_left = 0;
    int sw_left = 0;
    for (int i = 0; i < 3000; i++) begin
      if (btn_left == 0) begin
        btn_i = ($urandom_range(0, 3) != 0);
        btn_left = $urandom_range(1, 40);
      end
      if (sw_left == 0) begin
        sw_rst_req_i = ($urandom_range(0, 9) < 3);
        sw_left = $urandom_range(1, 60);
      end
      btn_left--;
      sw_left--;
      cycle();
      got = {x_clk_rst_o, x_core_rst_o, rst_done_o};
      n_checks++;
      if (got !== {m_clk, m_core, m_core}) begin
        n_fail++;
        $display("FAIL random_model cyc=%0d got=%b exp=%b", i, got, {m_clk, m_core, m_core});
      end
    end
    btn_i = 1'b1;
    sw_rst_req_i = 1'b0;
    repeat (100) cycle();
  endtask

  task automatic test_async_reset();
    logic [2:0] got;
    bit reached = 0;
    for (int i = 0; i < 200 && !reached; i++) begin
      sw_rst_req_i = (i < 3);
      cycle();
      if (m_clk && !m_core) reached = 1;
    end
    sw_rst_req_i = 1'b0;
    n_checks++;
    if (!reached) begin
      n_fail++;
      $display("FAIL async_reach_clk_up got=0 exp=1");
    end
    #2 x_reset = 1'b0;
    #1;
    got = {x_clk_rst_o, x_core_rst_o, rst_done_o};
    n_checks++;
    if (got !== 3'b000) begin
      n_fail++;
      $display("FAIL async_reset_immediate got=%b exp=000", got);
    end
    @(negedge clk_i);
    test_power_up();
  endtask

  initial begin
    test_reset();
    test_power_up();
    test_bounce();
    test_button_hold();
    test_sw_req();
    test_hold_triggers();
    test_random();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
